register_file: RTL and testbench



---
 rtl/register_file_pkg.sv | 11 +
 rtl/register_file.sv | 37 +++
 tb/tb_register_file.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/register_file_pkg.sv
// Shared LC-3 datapath constants and the register-index type used by the
// register file, the instruction decoder and the control unit.
package register_file_pkg;

   localparam int LC3_DATA_WIDTH = 16;
   localparam int LC3_NUM_REGS   = 8;
   localparam int LC3_ADDR_WIDTH = 3;

   typedef logic [LC3_ADDR_WIDTH-1:0] reg_idx_t;

endpackage

// File: rtl/register_file.sv
// LC-3 general-purpose register file: one synchronous write port from the bus
// and two independent combinational read ports, with no write-to-read bypass.
module register_file
   import register_file_pkg::*;
#(
   parameter int DATA_WIDTH = LC3_DATA_WIDTH,
   parameter int NUM_REGS   = LC3_NUM_REGS,
   parameter int ADDR_WIDTH = LC3_ADDR_WIDTH
) (
   input  logic                  i_CLK,
   input  logic                  i_RST_N,
   input  logic                  i_LD_REG,
   input  logic [ADDR_WIDTH-1:0] i_DR_Addr,
   input  logic [ADDR_WIDTH-1:0] i_SR1_Addr,
   input  logic [ADDR_WIDTH-1:0] i_SR2_Addr,
   input  logic [DATA_WIDTH-1:0] i_bus,
   output logic [DATA_WIDTH-1:0] o_SR1,
   output logic [DATA_WIDTH-1:0] o_SR2
);

   logic [DATA_WIDTH-1:0] memory [0:NUM_REGS-1];

   // Reset wins over a write presented in the same cycle.
   always_ff @(posedge i_CLK) begin
      if (!i_RST_N) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            memory[i] <= '0;
         end
      end else if (i_LD_REG) begin
         memory[i_DR_Addr] <= i_bus;
      end
   end

   assign o_SR1 = memory[i_SR1_Addr];
   assign o_SR2 = memory[i_SR2_Addr];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized
// traffic compared against an array model of the eight registers.
module tb_register_file;

   logic        clk;
   logic        rst_n;
   logic        ld;
   logic [2:0]  dr;
   logic [2:0]  sr1;
   logic [2:0]  sr2;
   logic [15:0] bus;
   logic [15:0] sr1_out;
   logic [15:0] sr2_out;

   logic [15:0] model [8];
   int          n_cmp;
   int          n_bad;

   register_file UUT (
      .i_CLK      (clk),
      .i_RST_N    (rst_n),
      .i_LD_REG   (ld),
      .i_DR_Addr  (dr),
      .i_SR1_Addr (sr1),
      .i_SR2_Addr (sr2),
      .i_bus      (bus),
      .o_SR1      (sr1_out),
      .o_SR2      (sr2_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One rising edge; the model applies the register-file rules to the
   // inputs seen at that edge, then outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) model[i] = 16'h0000;
      end else if (ld) begin
         model[dr] = bus;
      end
      #1;
   endtask

   task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
      ld = 1'b1; dr = a; bus = d;
      step();
      ld = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) write_reg(3'(i), 16'hFFFF);
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (UUT.memory[i] !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL prefill r%0d: got %h want ffff", i, UUT.memory[i]);
         end
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sr1 = 3'(i); sr2 = 3'(7 - i);
         #1;
         n_cmp++;
         if (UUT.memory[i] !== 16'h0000 || sr1_out !== 16'h0000 || sr2_out !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset r%0d: mem=%h sr1=%h sr2=%h want 0000", i, UUT.memory[i], sr1_out, sr2_out);
         end
      end
   endtask

   task automatic test_basic_write();
      write_reg(3'd1, 16'h000F);
      write_reg(3'd4, 16'h00F0);
      for (int i = 0; i < 8; i++) begin
         logic [15:0] want;
         want = (i == 1) ? 16'h000F : (i == 4) ? 16'h00F0 : 16'h0000;
         n_cmp++;
         if (UUT.memory[i] !== want) begin
            n_bad++;
            $display("FAIL basic_write r%0d: got %h want %h", i, UUT.memory[i], want);
         end
      end
   endtask

   task automatic test_write_disabled();
      ld = 1'b0; dr = 3'd2; bus = 16'hABCD;
      repeat (4) step();
      n_cmp++;
      if (UUT.memory[2] !== 16'h0000) begin
         n_bad++;
         $display("FAIL write_disabled r2: got %h want 0000", UUT.memory[2]);
      end
   endtask

   task automatic test_read_ports();
      sr1 = 3'd1; #1;
      n_cmp++;
      if (sr1_out !== 16'h000F) begin n_bad++; $display("FAIL sr1_r1: got %h want 000f", sr1_out); end
      sr1 = 3'd4; #1;
      n_cmp++;
      if (sr1_out !== 16'h00F0) begin n_bad++; $display("FAIL sr1_r4: got %h want 00f0", sr1_out); end
      sr2 = 3'd1; #1;
      n_cmp++;
      if (sr2_out !== 16'h000F) begin n_bad++; $display("FAIL sr2_r1: got %h want 000f", sr2_out); end
      sr2 = 3'd4; #1;
      n_cmp++;
      if (sr2_out !== 16'h00F0) begin n_bad++; $display("FAIL sr2_r4: got %h want 00f0", sr2_out); end
      sr1 = 3'd1; sr2 = 3'd4; #1;
      n_cmp++;
      if (sr1_out !== 16'h000F || sr2_out !== 16'h00F0) begin
         n_bad++;
         $display("FAIL dual_read: got %h/%h want 000f/00f0", sr1_out, sr2_out);
      end
   endtask

   task automatic test_collision();
      write_reg(3'd7, 16'h1111);
      ld = 1'b1; dr = 3'd7; sr1 = 3'd7; sr2 = 3'd7; bus = 16'hF000;
      #1;
      n_cmp++;
      if (sr1_out !== 16'h1111 || sr2_out !== 16'h1111) begin
         n_bad++;
         $display("FAIL collision_before: got %h/%h want 1111/1111", sr1_out, sr2_out);
      end
      step();
      ld = 1'b0;
      n_cmp++;
      if (sr1_out !== 16'hF000 || sr2_out !== 16'hF000) begin
         n_bad++;
         $display("FAIL collision_after: got %h/%h want f000/f000", sr1_out, sr2_out);
      end
   endtask

   task automatic test_reset_over_write();
      write_reg(3'd3, 16'h5555);
      rst_n = 1'b0; ld = 1'b1; dr = 3'd3; bus = 16'h1234;
      step();
      rst_n = 1'b1; ld = 1'b0;
      n_cmp++;
      if (UUT.memory[3] !== 16'h0000) begin
         n_bad++;
         $display("FAIL reset_over_write r3: got %h want 0000", UUT.memory[3]);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         rst_n = ($urandom_range(0, 31) != 0);
         ld    = $urandom_range(0, 1);
         dr    = 3'($urandom_range(0, 7));
         sr1   = 3'($urandom_range(0, 7));
         sr2   = ($urandom_range(0, 3) == 0) ? dr : 3'($urandom_range(0, 7));
         bus   = 16'($urandom);
         #1;
         n_cmp++;
         if (sr1_out !== model[sr1] || sr2_out !== model[sr2]) begin
            n_bad++;
            $display("FAIL random_pre #%0d: got %h/%h want %h/%h", n, sr1_out, sr2_out, model[sr1], model[sr2]);
         end
         step();
         n_cmp++;
         if (sr1_out !== model[sr1] || sr2_out !== model[sr2]) begin
            n_bad++;
            $display("FAIL random_post #%0d: got %h/%h want %h/%h", n, sr1_out, sr2_out, model[sr1], model[sr2]);
         end
      end
      rst_n = 1'b1; ld = 1'b0;
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      rst_n = 1'b1; ld = 1'b0; dr = '0; sr1 = '0; sr2 = '0; bus = '0;
      for (int i = 0; i < 8; i++) model[i] = 16'h0000;
      @(negedge clk);
      test_reset();
      test_basic_write();
      test_write_disabled();
      test_read_ports();
      test_collision();
      test_reset_over_write();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
